ping_pong_ctrl: RTL and testbench

- Sequencer that configures and drives an external 2-digit BCD up/down counter (00..99) in ping-pong mode.
- Accepts a job (BCD limit plus round count) over a valid/ready handshake and clears the counter.
- Steers count direction/enable so the counter bounces 00 -> limit -> 00, counts completed rounds, then pulses done.
- Sits between the host/config logic and the BCD counter datapath; it owns all direction and turnaround decisions.

---
 rtl/ping_pong_pkg.sv | 16 +
 rtl/bcd_limit_check.sv | 20 ++
 rtl/ping_pong_ctrl.sv | 139 +++++++++++++
 tb/tb_ping_pong_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ping_pong_pkg.sv
// ping_pong_pkg: shared state encoding and constants for the ping-pong BCD counter sequencer
package ping_pong_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        UP    = 3'd2,
        DOWN  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic       DIR_UP   = 1'b1;
    localparam logic       DIR_DOWN = 1'b0;

endpackage

// File: rtl/bcd_limit_check.sv
// bcd_limit_check: validates a two-digit BCD limit and a round count for a job request
module bcd_limit_check
    import ping_pong_pkg::*;
#(
    parameter int ROUND_W = 8
) (
    input  logic [3:0]         u1,
    input  logic [3:0]         u0,
    input  logic [ROUND_W-1:0] rounds,
    output logic               valid,
    output logic               is_zero
);

    // Well-formed means both digits decimal and at least one round; a zero limit is flagged separately
    always_comb begin
        valid   = (u1 <= BCD_MAX) && (u0 <= BCD_MAX) && (rounds != '0);
        is_zero = (u1 == 4'd0) && (u0 == 4'd0);
    end

endmodule

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl: steers an external BCD up/down counter to bounce 00 -> limit -> 00 for a requested number of rounds
module ping_pong_ctrl
    import ping_pong_pkg::*;
#(
    parameter int ROUND_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [3:0]         cfg_u1,
    input  logic [3:0]         cfg_u0,
    input  logic [ROUND_W-1:0] cfg_rounds,
    input  logic               pause,
    input  logic               abort,
    input  logic [3:0]         cnt_d1,
    input  logic [3:0]         cnt_d0,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               cnt_dir,
    output logic [3:0]         lim_u1,
    output logic [3:0]         lim_u0,
    output logic               busy,
    output logic [ROUND_W-1:0] rounds_done,
    output logic               done,
    output logic               err
);

    state_e               state_q, state_d;
    logic [3:0]           lim_u1_q, lim_u1_d;
    logic [3:0]           lim_u0_q, lim_u0_d;
    logic [ROUND_W-1:0]   rounds_q, rounds_d;
    logic [ROUND_W-1:0]   rounds_done_q, rounds_done_d;
    logic                 err_q, err_d;

    logic                 cfg_valid_fmt;
    logic                 cfg_zero;
    logic                 accept;
    logic                 cfg_ok;
    logic                 running;
    logic                 turn;
    logic                 advance;
    logic [ROUND_W-1:0]   rounds_inc;

    bcd_limit_check #(
        .ROUND_W (ROUND_W)
    ) u_check (
        .u1      (cfg_u1),
        .u0      (cfg_u0),
        .rounds  (cfg_rounds),
        .valid   (cfg_valid_fmt),
        .is_zero (cfg_zero)
    );

    // Turnaround detection on raw BCD digits; out-of-range digits never match the limit or 00
    always_comb begin
        accept     = cfg_valid && cfg_ready;
        cfg_ok     = cfg_valid_fmt && !cfg_zero;
        running    = (state_q == UP) || (state_q == DOWN);
        turn       = ((state_q == UP) && (cnt_d1 == lim_u1_q) && (cnt_d0 == lim_u0_q)) ||
                     ((state_q == DOWN) && (cnt_d1 == 4'd0) && (cnt_d0 == 4'd0));
        advance    = turn && !pause && !abort;
        rounds_inc = rounds_done_q + 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort beats pause, pause beats a turnaround
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (accept && cfg_ok) ? CLEAR : IDLE;
            CLEAR:   state_d = abort ? IDLE : UP;
            UP:      state_d = abort ? IDLE : (advance ? DOWN : UP);
            DOWN:    state_d = abort ? IDLE :
                               !advance ? DOWN :
                               (rounds_inc == rounds_q) ? DONE : UP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; cfg_ready drops with rst without waiting for a clock
    always_comb begin
        cfg_ready = (state_q == IDLE) && !rst;
        cnt_clr   = state_q == CLEAR;
        cnt_en    = running && !pause && !abort && !turn;
        cnt_dir   = (state_q == DOWN) ? DIR_DOWN : DIR_UP;
        busy      = state_q != IDLE;
        done      = state_q == DONE;
    end

    // Job latches, round counter and the reject pulse
    always_comb begin
        lim_u1_d      = lim_u1_q;
        lim_u0_d      = lim_u0_q;
        rounds_d      = rounds_q;
        rounds_done_d = rounds_done_q;
        err_d         = accept && !cfg_ok;
        if (accept && cfg_ok) begin
            lim_u1_d      = cfg_u1;
            lim_u0_d      = cfg_u0;
            rounds_d      = cfg_rounds;
            rounds_done_d = '0;
        end else if ((state_q == DOWN) && advance) begin
            rounds_done_d = rounds_inc;
        end
    end

    // Job register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_u1_q      <= 4'd0;
            lim_u0_q      <= 4'd0;
            rounds_q      <= '0;
            rounds_done_q <= '0;
            err_q         <= 1'b0;
        end else begin
            lim_u1_q      <= lim_u1_d;
            lim_u0_q      <= lim_u0_d;
            rounds_q      <= rounds_d;
            rounds_done_q <= rounds_done_d;
            err_q         <= err_d;
        end
    end

    assign lim_u1      = lim_u1_q;
    assign lim_u0      = lim_u0_q;
    assign rounds_done = rounds_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb_ping_pong_ctrl: drives jobs into ping_pong_ctrl around a behavioural BCD counter and checks against an arithmetic bounce model
module tb_ping_pong_ctrl;

    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [3:0]    cfg_u1 = 4'd0;
    logic [3:0]    cfg_u0 = 4'd0;
    logic [RW-1:0] cfg_rounds = '0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic [3:0]    cnt_d1 = 4'd0;
    logic [3:0]    cnt_d0 = 4'd0;
    logic          cnt_clr, cnt_en, cnt_dir;
    logic [3:0]    lim_u1, lim_u0;
    logic          busy;
    logic [RW-1:0] rounds_done;
    logic          done, err;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    int         m_lim = 0, m_r = 0, k = 0, m_rdone = 0;
    bit         m_clear = 0, m_active = 0, m_done = 0, m_err = 0;
    logic [3:0] m_u1 = 4'd0, m_u0 = 4'd0;

    always #5 clk = ~clk;

    ping_pong_ctrl #(.ROUND_W(RW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_u1(cfg_u1), .cfg_u0(cfg_u0), .cfg_rounds(cfg_rounds),
        .pause(pause), .abort(abort), .cnt_d1(cnt_d1), .cnt_d0(cnt_d0),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .lim_u1(lim_u1), .lim_u0(lim_u0), .busy(busy),
        .rounds_done(rounds_done), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit cfg_ok();
        return cfg_u1 <= 4'd9 && cfg_u0 <= 4'd9 && (cfg_u1 != 4'd0 || cfg_u0 != 4'd0) && cfg_rounds != '0;
    endfunction

    task automatic count_step(input bit clr, input bit en, input bit dir);
        int v;
        v = cnt_d1 * 10 + cnt_d0;
        if (clr) v = 0;
        else if (en) v = dir ? (v + 1) % 100 : (v + 99) % 100;
        cnt_d1 = 4'(v / 10);
        cnt_d0 = 4'(v % 10);
    endtask

    task automatic reset_checks();
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_en", cnt_en, 0);
        check("rst_dir", cnt_dir, 1);
        check("rst_clr", cnt_clr, 0);
        check("rst_lim_u1", lim_u1, 0);
        check("rst_lim_u0", lim_u0, 0);
        check("rst_rounds_done", rounds_done, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic cycle();
        int per, p, val;
        bit up, tn, ebusy, s_clr, s_en, s_dir;
        @(negedge clk);
        ebusy = m_clear || m_active || m_done;
        per = 2 * m_lim + 2;
        check("busy", busy, ebusy);
        check("cfg_ready", cfg_ready, !ebusy);
        check("done", done, m_done);
        check("err", err, m_err);
        check("cnt_clr", cnt_clr, m_clear);
        check("lim_u1", lim_u1, m_u1);
        check("lim_u0", lim_u0, m_u0);
        if (m_active) begin
            p   = k % per;
            up  = p <= m_lim;
            val = up ? p : per - 1 - p;
            tn  = (p == m_lim) || (p == per - 1);
            check("cnt_val", cnt_d1 * 10 + cnt_d0, val);
            check("cnt_dir", cnt_dir, up);
            check("cnt_en", cnt_en, !pause && !abort && !tn);
            check("rounds_done", rounds_done, k / per);
        end else begin
            check("cnt_en_idle", cnt_en, 0);
            check("cnt_dir_idle", cnt_dir, 1);
            check("rounds_done", rounds_done, m_rdone);
        end
        if (done === 1'b1) n_done++;
        s_clr = cnt_clr;
        s_en  = cnt_en;
        s_dir = cnt_dir;
        m_err = !ebusy && cfg_valid && !cfg_ok();
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
                m_rdone  = k / per;
            end else if (!pause) begin
                k++;
                if (k == m_r * per) begin
                    m_active = 0;
                    m_done   = 1;
                    m_rdone  = m_r;
                end
            end
        end else if (m_clear) begin
            m_clear = 0;
            if (!abort) begin
                m_active = 1;
                k = 0;
            end
        end else if (cfg_valid && cfg_ok()) begin
            m_u1    = cfg_u1;
            m_u0    = cfg_u0;
            m_lim   = cfg_u1 * 10 + cfg_u0;
            m_r     = int'(cfg_rounds);
            m_rdone = 0;
            m_clear = 1;
        end
        @(posedge clk);
        #1;
        count_step(s_clr, s_en, s_dir);
    endtask

    // mode: 0 plain, 1 random pause/abort/noise, 2 pause 5 at count 02 up, 3 abort at 05 down in round 2, 4 async reset mid-UP
    task automatic run_job(input logic [3:0] u1, input logic [3:0] u0, input int r, input int mode);
        int guard, pleft, per, p, val, lim;
        bit pdone, up, ok;
        guard = 0; pleft = 0; pdone = 0;
        cfg_u1 = u1; cfg_u0 = u0; cfg_rounds = r[RW-1:0]; cfg_valid = 1'b1;
        ok  = cfg_ok();
        lim = u1 * 10 + u0;
        n_done = 0;
        cycle();
        cfg_valid = 1'b0;
        while ((m_clear || m_active || m_done || m_err) && guard < 3000) begin
            pause = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
            per = 2 * m_lim + 2;
            p   = k % per;
            up  = p <= m_lim;
            val = up ? p : per - 1 - p;
            if (mode == 1) begin
                pause = $urandom_range(0, 4) == 0;
                abort = $urandom_range(0, 149) == 0;
                if (m_clear || m_active) begin
                    cfg_valid  = 1'(($urandom_range(0, 1)));
                    cfg_u1     = 4'($urandom_range(0, 9));
                    cfg_u0     = 4'($urandom_range(0, 9));
                    cfg_rounds = RW'($urandom_range(1, 3));
                end
            end
            if (mode == 2) begin
                if (!pdone && m_active && up && val == 2) begin
                    pleft = 5;
                    pdone = 1;
                end
                if (pleft > 0) begin
                    pause = 1'b1;
                    pleft--;
                end
            end
            if (mode == 3) abort = m_active && !up && val == 5 && k / per == 1;
            if (mode == 4 && m_active && up && val == 3) begin
                #2 rst = 1'b1;
                #1 reset_checks();
                m_clear = 0; m_active = 0; m_done = 0; m_err = 0;
                m_u1 = 4'd0; m_u0 = 4'd0; m_lim = 0; m_r = 0; m_rdone = 0; k = 0;
                @(posedge clk);
                #1 rst = 1'b0;
                break;
            end
            cycle();
            guard++;
        end
        pause = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        check("job_timeout", guard < 3000, 1);
        if (mode == 0 || mode == 2) begin
            check("job_len", guard, ok ? r * (2 * lim + 2) + (mode == 2 ? 5 : 0) + 2 : 1);
            check("done_pulses", n_done, ok ? 1 : 0);
        end
        if (mode == 3) check("abort_no_done", n_done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_checks();
        rst = 1'b0;
        run_job(4'd0, 4'd3, 2, 0);
        run_job(4'd0, 4'hA, 1, 0);
        run_job(4'd0, 4'd0, 1, 0);
        run_job(4'd1, 4'd2, 0, 0);
        run_job(4'hC, 4'd1, 1, 0);
        run_job(4'd9, 4'd9, 1, 0);
        run_job(4'd0, 4'd5, 1, 2);
        run_job(4'd0, 4'd7, 3, 3);
        run_job(4'hB, 4'd0, 2, 0);
        repeat (25) begin
            run_job(4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), $urandom_range(0, 3), 1);
        end
        run_job(4'd0, 4'd6, 2, 4);
        run_job(4'd0, 4'd1, 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
